// File: rtl/msdf_pkg.sv
// Shared definitions for the MSDF datapath blocks (multiplier, serializer, converter).
// Signed-digit codes travel as {positive flag, negative flag}.
package msdf_pkg;

    localparam logic [1:0] SD_ZERO = 2'b00;
    localparam logic [1:0] SD_POS  = 2'b10;
    localparam logic [1:0] SD_NEG  = 2'b01;
    localparam logic [1:0] SD_BAD  = 2'b11;

    localparam int MSDF_DEFAULT_N = 8;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } conv_state_t;

    // Code 11 is legal on the wire (it reads as zero) but never produced by a clean source.
    function automatic logic sd_is_redundant(input logic [1:0] digit);
        return digit == SD_BAD;
    endfunction

endpackage

// File: rtl/msdf_otf_step.sv
// One step of on-the-fly conversion: appends a signed digit to the Q / QM register pair.
// QM always tracks Q minus one unit in the last position, so no carry ever propagates.
module msdf_otf_step
    import msdf_pkg::*;
#(
    parameter int W = MSDF_DEFAULT_N + 1
) (
    input  logic [W-1:0] q,
    input  logic [W-1:0] qm,
    input  logic [1:0]   digit,
    output logic [W-1:0] q_next,
    output logic [W-1:0] qm_next
);

    // Zero and the redundant 11 code share the default branch.
    always_comb begin
        q_next  = {q[W-2:0], 1'b0};
        qm_next = {qm[W-2:0], 1'b1};
        case (digit)
            SD_POS: begin
                q_next  = {q[W-2:0], 1'b1};
                qm_next = {q[W-2:0], 1'b0};
            end
            SD_NEG: begin
                q_next  = {qm[W-2:0], 1'b1};
                qm_next = {qm[W-2:0], 1'b0};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/msdf_otf_converter.sv
// Rebuilds an N-digit MSDF signed-digit frame into an (N+1)-bit two's-complement word.
// Optional sticky protocol-error flag 'err' is enabled with `define MSDF_CONV_ERR_EN.
module msdf_otf_converter
    import msdf_pkg::*;
#(
    parameter int N = MSDF_DEFAULT_N
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [1:0]   din,
    input  logic         din_valid,
    input  logic         din_first,
    output logic         din_ready,
    output logic [N:0]   dout,
    output logic         dout_valid,
    input  logic         dout_ready
`ifdef MSDF_CONV_ERR_EN
    ,
    output logic         err
`endif
);

    localparam int W  = N + 1;
    localparam int CW = $clog2(N + 1);

    conv_state_t   state;
    logic [W-1:0]  q;
    logic [W-1:0]  qm;
    logic [CW-1:0] cnt;

    logic          accept;
    logic          last_digit;
    logic [W-1:0]  step_q;
    logic [W-1:0]  step_qm;
    logic [W-1:0]  q_next;
    logic [W-1:0]  qm_next;

    assign accept     = din_valid && din_ready;
    assign last_digit = (state == ACCUM) && !din_first && (cnt == CW'(N - 1));

    // A first digit always starts from the reset pair, which also covers a mid-frame restart.
    assign step_q  = din_first ? '0 : q;
    assign step_qm = din_first ? '1 : qm;

    msdf_otf_step #(
        .W(W)
    ) u_step (
        .q      (step_q),
        .qm     (step_qm),
        .digit  (din),
        .q_next (q_next),
        .qm_next(qm_next)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            q          <= '0;
            qm         <= '1;
            cnt        <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            din_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && din_first) begin
                        q     <= q_next;
                        qm    <= qm_next;
                        cnt   <= CW'(1);
                        state <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        if (last_digit) begin
                            dout       <= q_next;
                            dout_valid <= 1'b1;
                            din_ready  <= 1'b0;
                            q          <= '0;
                            qm         <= '1;
                            cnt        <= '0;
                            state      <= HOLD;
                        end else begin
                            q   <= q_next;
                            qm  <= qm_next;
                            cnt <= din_first ? CW'(1) : cnt + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (dout_ready) begin
                        dout_valid <= 1'b0;
                        din_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state      <= IDLE;
                    dout_valid <= 1'b0;
                    din_ready  <= 1'b1;
                end
            endcase
        end
    end

`ifdef MSDF_CONV_ERR_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err <= 1'b0;
        end else if (accept && (sd_is_redundant(din) ||
                                (state == IDLE && !din_first) ||
                                (state == ACCUM && din_first))) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_msdf_otf_converter.sv
// Scoreboard bench for msdf_otf_converter (N = 8): directed frames, stalls, restarts, resets and random traffic.
// Frame values are computed as sum(d_i * 2^(N-i)) and reduced to N+1 bits.
module tb_msdf_otf_converter;
    import msdf_pkg::*;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   din;
    logic         din_valid;
    logic         din_first;
    logic         din_ready;
    logic [N:0]   dout;
    logic         dout_valid;
    logic         dout_ready;
`ifdef MSDF_CONV_ERR_EN
    logic         err;
`endif

    int           vectors = 0;
    int           miscompares = 0;
    logic [N:0]   exp_q[$];
    logic         rand_ready = 1'b0;
    logic         ready_force = 1'b1;
    logic         holding = 1'b0;
    logic [N:0]   held_value = '0;
    logic [1:0]   digs [N];

    msdf_otf_converter #(
        .N(N)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .din_valid (din_valid),
        .din_first (din_first),
        .din_ready (din_ready),
        .dout      (dout),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready)
`ifdef MSDF_CONV_ERR_EN
        ,
        .err       (err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int sd_val(input logic [1:0] d);
        if (d == SD_POS) return 1;
        if (d == SD_NEG) return -1;
        return 0;
    endfunction

    // Consumer side: random or forced back-pressure, changed just after each rising edge.
    initial begin
        dout_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            dout_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
        end
    end

    // Monitor: compare each new output word against the scoreboard, then demand stability until taken.
    always @(negedge clk) begin
        if (reset) begin
            holding = 1'b0;
        end else if (dout_valid) begin
            if (!holding) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_dout_valid", 32'(dout_valid), 32'd0);
                end else begin
                    check("dout_value", 32'(dout), 32'(exp_q.pop_front()));
                end
                held_value = dout;
                holding = 1'b1;
            end else begin
                check("dout_stable", 32'(dout), 32'(held_value));
            end
            check("din_ready_in_hold", 32'(din_ready), 32'd0);
            if (dout_ready) holding = 1'b0;
        end
    end

    task automatic send_digit(input logic [1:0] d, input logic first);
        int waited;
        din = d;
        din_first = first;
        din_valid = 1'b1;
        waited = 0;
        @(negedge clk);
        while (!din_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!din_ready) check("din_ready_timeout", 32'(din_ready), 32'd1);
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        din_first = 1'b0;
        din = 2'($urandom_range(0, 3));
    endtask

    task automatic stall(input int cycles);
        din_valid = 1'b0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [1:0] frame [N], input int stall_pct,
                                 input int stall_at, input int stall_len);
        int value;
        value = 0;
        for (int i = 0; i < N; i++) begin
            if (i == stall_at) stall(stall_len);
            else if (i > 0 && int'($urandom_range(0, 99)) < stall_pct) stall(int'($urandom_range(1, 3)));
            send_digit(frame[i], logic'(i == 0));
            value += sd_val(frame[i]) * (1 << (N - 1 - i));
        end
        exp_q.push_back((N + 1)'(value));
        check("latency_dout_valid", 32'(dout_valid), 32'd1);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic checkOutput();
        @(negedge clk);
        check("reset_dout", 32'(dout), 32'd0);
        check("reset_dout_valid", 32'(dout_valid), 32'd0);
        check("reset_din_ready", 32'(din_ready), 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput();
    endtask

    initial begin
        reset = 1'b1;
        din = SD_ZERO;
        din_valid = 1'b0;
        din_first = 1'b0;
        #1;
        checkOutput();
        do_reset();

        digs = '{SD_POS, SD_ZERO, SD_ZERO, SD_ZERO, SD_ZERO, SD_ZERO, SD_ZERO, SD_ZERO};
        applyStimulus(digs, 0, -1, 0);
        digs = '{SD_NEG, SD_ZERO, SD_POS, SD_ZERO, SD_ZERO, SD_ZERO, SD_ZERO, SD_ZERO};
        applyStimulus(digs, 0, -1, 0);
        digs = '{SD_POS, SD_POS, SD_POS, SD_POS, SD_POS, SD_POS, SD_POS, SD_POS};
        applyStimulus(digs, 0, -1, 0);
        digs = '{SD_NEG, SD_NEG, SD_NEG, SD_NEG, SD_NEG, SD_NEG, SD_NEG, SD_NEG};
        applyStimulus(digs, 0, -1, 0);
        wait_drain();

        // Back-pressured frame with a mid-frame stall and ignored digits offered during HOLD.
        ready_force = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        digs = '{SD_POS, SD_NEG, SD_ZERO, SD_ZERO, SD_ZERO, SD_ZERO, SD_ZERO, SD_ZERO};
        applyStimulus(digs, 0, 4, 3);
        for (int i = 0; i < 5; i++) begin
            din_valid = 1'b1;
            din_first = 1'b1;
            din = SD_NEG;
            @(posedge clk);
            #1;
            check("hold_din_ready", 32'(din_ready), 32'd0);
            check("hold_dout_valid", 32'(dout_valid), 32'd1);
        end
        din_valid = 1'b0;
        din_first = 1'b0;
        ready_force = 1'b1;
        wait_drain();

        // Reset after digit 3 loses the partial frame.
        send_digit(SD_POS, 1'b1);
        send_digit(SD_NEG, 1'b0);
        send_digit(SD_POS, 1'b0);
        do_reset();
        digs = '{SD_POS, SD_ZERO, SD_ZERO, SD_ZERO, SD_ZERO, SD_ZERO, SD_ZERO, SD_ZERO};
        applyStimulus(digs, 0, -1, 0);
        wait_drain();

        // Random traffic: stray digits in IDLE, abandoned prefixes, stalls, random back-pressure.
        rand_ready = 1'b1;
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 4) == 0) send_digit(2'($urandom_range(0, 3)), 1'b0);
            if ($urandom_range(0, 4) == 0) begin
                send_digit(2'($urandom_range(0, 3)), 1'b1);
                for (int k = 0; k < int'($urandom_range(1, N - 2)); k++)
                    send_digit(2'($urandom_range(0, 3)), 1'b0);
            end
            for (int i = 0; i < N; i++) digs[i] = 2'($urandom_range(0, 3));
            applyStimulus(digs, 25, -1, 0);
        end
        rand_ready = 1'b0;
        wait_drain();

`ifdef MSDF_CONV_ERR_EN
        do_reset();
        check("err_after_reset", 32'(err), 32'd0);
        digs = '{SD_POS, SD_BAD, SD_POS, SD_ZERO, SD_ZERO, SD_ZERO, SD_ZERO, SD_ZERO};
        applyStimulus(digs, 0, -1, 0);
        wait_drain();
        check("err_code11", 32'(err), 32'd1);
        do_reset();
        check("err_cleared", 32'(err), 32'd0);
        for (int k = 0; k < 4; k++) send_digit(SD_POS, logic'(k == 0));
        check("err_before_restart", 32'(err), 32'd0);
        digs = '{SD_NEG, SD_ZERO, SD_POS, SD_ZERO, SD_ZERO, SD_ZERO, SD_ZERO, SD_ZERO};
        applyStimulus(digs, 0, -1, 0);
        wait_drain();
        check("err_restart", 32'(err), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/msdf_otf_converter.md
Name: msdf_otf_converter

Overview:
- Receive-side companion of msdf_mult. Consumes the most-significant-digit-first signed-digit product stream (2-bit digits on p) and rebuilds a conventional two's-complement fraction using on-the-fly conversion.
- Uses two registers, Q and QM, so there is no carry-propagate step.
- Sits directly downstream of msdf_mult. Presents one N-digit frame as a parallel word with a valid/ready handshake.

Parameters:
- N, default 8: digits per frame, minimum 2. The output word is N+1 bits: a sign bit plus N fraction bits.
- CW, default $clog2(N+1): digit counter width. Localparam, derived, not overridable.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- din  input  2  signed digit. Bit1 = positive flag, bit0 = negative flag. Encodings: 00 = 0, 10 = +1, 01 = -1, 11 = 0.
- din_valid  input  1  din carries a digit this cycle.
- din_first  input  1  marks digit 1 (weight 2^-1) of a frame.
- din_ready  output  1  converter can accept a digit this cycle.
- dout  output  N+1  two's-complement result; value = dout / 2^N.
- dout_valid  output  1  dout holds a completed frame.
- dout_ready  input  1  consumer accepts dout.

Behaviour:
- Reset (asynchronous, any state): state = IDLE, Q = 0, QM = all ones (-1), cnt = 0, dout = 0, dout_valid = 0, din_ready = 1.
- A digit is accepted when din_valid && din_ready.
- Digit update of the (N+1)-bit registers: left shift, discard MSB, append one LSB.
  - d = +1: Q <= {Q,1}, QM <= {Q,0}
  - d = 0: Q <= {Q,0}, QM <= {QM,1}
  - d = -1: Q <= {QM,1}, QM <= {QM,0}
  - Invariant: QM = Q - 2^-j after j digits.
  - The result range is ±(1 - 2^-N), so it always fits in N+1 bits; no overflow handling.
- State IDLE:
  - din_ready = 1.
  - Accepted digit with din_first: apply the digit to the reset values (Q = 0, QM = -1), set cnt = 1, go to ACCUM.
  - Accepted digit without din_first: dropped, no state change.
- State ACCUM:
  - din_ready = 1.
  - Accepted digit without din_first: apply the update, cnt++.
  - Accepted digit with din_first: restart the frame exactly as from IDLE. The partial frame is discarded and cnt = 1.
  - When the accepted digit is digit N: dout <= final Q, dout_valid <= 1, go to HOLD. Q, QM and cnt return to reset values.
  - Cycles with din_valid = 0 are stalls; state is held.
- State HOLD:
  - din_ready = 0; dout_valid = 1; dout stable.
  - On dout_ready: dout_valid <= 0 at the next edge, go to IDLE. dout keeps its last value.
- Latency: dout_valid rises on the edge after digit N is accepted.
- Throughput: at most one frame per N+1 cycles.
- Simultaneous events: reset overrides everything. din_valid in HOLD is ignored because din_ready is low.
- Reset mid-frame or mid-HOLD: partial data is lost; no dout_valid is produced for that frame.

Optional Feature:
- Macro: MSDF_CONV_ERR_EN.
- Defined:
  - Adds output port err (1 bit, reset 0).
  - err is sticky and set on any of: code 11 accepted, a digit without din_first accepted in IDLE, or din_first accepted in ACCUM.
  - err clears only on reset. Conversion behaviour is otherwise unchanged.
- Not defined: no err port; the same conditions are handled silently as described in Behaviour.

Decomposition:
- Shared package msdf_pkg:
  - Digit encoding localparams: SD_ZERO = 2'b00, SD_POS = 2'b10, SD_NEG = 2'b01.
  - State encoding: IDLE, ACCUM, HOLD.
  - Default digit count: 8.
  - The package is shared with msdf_mult and the MSDF serializer.
- Sub-module msdf_otf_step (combinational): maps Q, QM and a digit to the next Q and QM. This keeps the recurrence independently testable.
- The FSM, counter and handshake stay in msdf_otf_converter.

Test Plan:
All scenarios use N = 8, with dout_ready = 1 unless stated.
- Digits +1,0,0,0,0,0,0,0 (din_first on digit 1) -> dout = 9'h080 (0.5); dout_valid on the edge after digit 8, high for one cycle.
- Digits -1,0,+1,0,0,0,0,0 -> dout = 9'h1A0 (-0.375).
- Eight +1 digits -> 9'h0FF; eight -1 digits -> 9'h101.
- Digits +1,-1,0×6 with din_valid deasserted 3 cycles mid-frame, and dout_ready = 0 for 5 cycles after completion:
  - dout = 9'h040.
  - din_ready = 0 and dout stable throughout HOLD.
  - din_valid pulses offered during HOLD do not disturb dout.
- Assert reset after digit 3 of a frame, then send +1,0×7 -> exactly one dout_valid, with dout = 9'h080.
- With MSDF_CONV_ERR_EN defined:
  - din_first after digit 4 -> err = 1, and the new frame converts correctly.
  - Code 11 within a frame -> err = 1, treated as 0.
  - err clears only on reset.
